// File: rtl/overture_core.sv
// Multicycle DW-bit core: FETCH/EXEC/MEM/HALT sequencer with ALU, branches,
// a latched I/O port and a req/ack data-RAM port.
`timescale 1ns/1ps
module overture_core #(
    parameter int unsigned DW  = 8,
    parameter int unsigned PCW = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PCW-1:0]  imem_addr,
    input  logic [DW+1:0]   imem_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic [DW-1:0]   dmem_rdata,
    input  logic            dmem_ack,
    input  logic [DW-1:0]   io_in,
    output logic [DW-1:0]   io_out,
    output logic            io_strobe,
    input  logic            resume,
    output logic            halted
);

    localparam int unsigned IW   = DW + 2;
    localparam int unsigned NREG = 6;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state;
    logic [PCW-1:0]  pc;
    logic [DW-1:0]   regs [NREG];
    logic            mem_rd;
    logic [2:0]      mem_dst;

    logic [1:0]      opc;
    logic [2:0]      src;
    logic [2:0]      dst;
    logic [PCW-1:0]  pc_inc;
    logic [DW-1:0]   alu_res;
    logic [DW-1:0]   src_val;
    logic            taken;
    logic            wb_en;
    logic [2:0]      wb_idx;
    logic [DW-1:0]   wb_val;

    assign opc       = imem_data[IW-1:IW-2];
    assign src       = imem_data[5:3];
    assign dst       = imem_data[2:0];
    assign pc_inc    = pc + PCW'(1);
    assign imem_addr = pc;
    assign dmem_addr = regs[4];

    always_comb begin
        alu_res = '0;
        case (imem_data[2:0])
            3'd0: alu_res = regs[1] | regs[2];
            3'd1: alu_res = ~(regs[1] & regs[2]);
            3'd2: alu_res = ~(regs[1] | regs[2]);
            3'd3: alu_res = regs[1] & regs[2];
            3'd4: alu_res = regs[1] + regs[2];
            3'd5: alu_res = regs[1] - regs[2];
            3'd6: alu_res = {regs[1][DW-2:0], 1'b0};
            3'd7: alu_res = {1'b0, regs[1][DW-1:1]};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        src_val = '0;
        case (src)
            3'd0: src_val = regs[0];
            3'd1: src_val = regs[1];
            3'd2: src_val = regs[2];
            3'd3: src_val = regs[3];
            3'd4: src_val = regs[4];
            3'd5: src_val = regs[5];
            3'd6: src_val = io_in;
            default: src_val = '0;
        endcase
    end

    // Branch condition on r3 read as a signed value
    always_comb begin
        taken = 1'b0;
        case (imem_data[2:0])
            3'd0: taken = 1'b0;
            3'd1: taken = (regs[3] == '0);
            3'd2: taken = regs[3][DW-1];
            3'd3: taken = regs[3][DW-1] || (regs[3] == '0);
            3'd4: taken = 1'b1;
            3'd5: taken = (regs[3] != '0);
            3'd6: taken = !regs[3][DW-1];
            3'd7: taken = !regs[3][DW-1] && (regs[3] != '0);
            default: taken = 1'b0;
        endcase
    end

    // Single writeback port: index 0-5 = registers, 6 = io_out
    always_comb begin
        wb_en  = 1'b0;
        wb_idx = '0;
        wb_val = '0;
        if (state == S_EXEC) begin
            case (opc)
                2'b00: begin
                    wb_en  = 1'b1;
                    wb_idx = 3'd0;
                    wb_val = imem_data[DW-1:0];
                end
                2'b01: begin
                    wb_en  = 1'b1;
                    wb_idx = 3'd3;
                    wb_val = alu_res;
                end
                2'b10: begin
                    wb_en  = (src != 3'd7) && (dst != 3'd7);
                    wb_idx = dst;
                    wb_val = src_val;
                end
                default: wb_en = 1'b0;
            endcase
        end else if (state == S_MEM && dmem_ack && mem_rd) begin
            wb_en  = 1'b1;
            wb_idx = mem_dst;
            wb_val = dmem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            io_out     <= '0;
            io_strobe  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_dst    <= '0;
        end else begin
            io_strobe <= 1'b0;
            if (wb_en) begin
                if (wb_idx == 3'd6) begin
                    io_out    <= wb_val;
                    io_strobe <= 1'b1;
                end else begin
                    for (int i = 0; i < NREG; i++)
                        if (wb_idx == 3'(i)) regs[i] <= wb_val;
                end
            end
            case (state)
                S_FETCH: state <= S_EXEC;
                S_EXEC: begin
                    mem_rd  <= (src == 3'd7);
                    mem_dst <= dst;
                    state   <= S_FETCH;
                    pc      <= pc_inc;
                    case (opc)
                        2'b10: begin
                            // pc advances only once the RAM acknowledges
                            if (src == 3'd7 && dst != 3'd7) begin
                                pc       <= pc;
                                state    <= S_MEM;
                                dmem_req <= 1'b1;
                                dmem_we  <= 1'b0;
                            end else if (src != 3'd7 && dst == 3'd7) begin
                                pc         <= pc;
                                state      <= S_MEM;
                                dmem_req   <= 1'b1;
                                dmem_we    <= 1'b1;
                                dmem_wdata <= src_val;
                            end
                        end
                        2'b11: begin
                            if (imem_data[3]) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end else if (taken) begin
                                pc <= PCW'(regs[0]);
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc_inc;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_overture_core.sv
// Bench for overture_core: directed timing checks plus random programs scored
// against an instruction-level reference model.
`timescale 1ns/1ps
module tb_overture_core;

    localparam int unsigned DW  = 8;
    localparam int unsigned PCW = 8;
    localparam int unsigned IW  = DW + 2;

    typedef struct {
        int       kind;   // 0 io write, 1 RAM write, 2 RAM read, 3 halt
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [PCW-1:0]  imem_addr;
    logic [IW-1:0]   imem_data = '0;
    logic            dmem_req;
    logic            dmem_we;
    logic [DW-1:0]   dmem_addr;
    logic [DW-1:0]   dmem_wdata;
    logic [DW-1:0]   dmem_rdata;
    logic            dmem_ack;
    logic [DW-1:0]   io_in;
    logic [DW-1:0]   io_out;
    logic            io_strobe;
    logic            resume;
    logic            halted;

    logic [IW-1:0]   rom  [256];
    logic [7:0]      dram [256];
    logic [7:0]      mmem [256];
    ev_t             exp_q [$];
    ev_t             tx_q [$];
    int              req_len_q [$];
    int              req_run = 0;
    int              n_cmp = 0;
    int              n_bad = 0;
    bit              sb_on = 0;
    bit              auto_resume = 1;
    bit              ack_hold = 0;
    int              ack_delay = -1;
    logic [7:0]      t2_exp [4] = '{8'd44, 8'd100, 8'h02, 8'h40};

    always #5 clk = ~clk;

    overture_core #(.DW(DW), .PCW(PCW)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .io_in(io_in), .io_out(io_out), .io_strobe(io_strobe),
        .resume(resume), .halted(halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_obs(input int kind, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        if (!sb_on || exp_q.size() == 0) return;
        e = exp_q.pop_front();
        n_cmp++;
        if (e.kind != kind || e.a !== a || e.b !== b) begin
            n_bad++;
            $display("FAIL sb_event: got kind=%0d a=%0h b=%0h expected kind=%0d a=%0h b=%0h",
                     kind, a, b, e.kind, e.a, e.b);
        end
    endtask

    function automatic void push_ev(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind;
        e.a = 8'(a);
        e.b = 8'(b);
        exp_q.push_back(e);
    endfunction

    // Instruction-level reference model producing the expected event stream
    task automatic model_run(input int n, input int io_val);
        int pc, a, b, v, sv, src, dst, cnd;
        int r [6];
        bit take;
        logic [IW-1:0] ins;
        pc = 0;
        for (int i = 0; i < 6; i++) r[i] = 0;
        for (int k = 0; k < n; k++) begin
            ins = rom[pc];
            case (ins[9:8])
                2'b00: begin r[0] = int'(ins[7:0]); pc = (pc + 1) % 256; end
                2'b01: begin
                    a = r[1]; b = r[2];
                    case (ins[2:0])
                        3'd0: v = a | b;
                        3'd1: v = 255 - (a & b);
                        3'd2: v = 255 - (a | b);
                        3'd3: v = a & b;
                        3'd4: v = (a + b) % 256;
                        3'd5: v = (a - b + 256) % 256;
                        3'd6: v = (a * 2) % 256;
                        default: v = a / 2;
                    endcase
                    r[3] = v;
                    pc = (pc + 1) % 256;
                end
                2'b10: begin
                    src = int'(ins[5:3]); dst = int'(ins[2:0]);
                    if (!(src == 7 && dst == 7)) begin
                        if (src < 6) v = r[src];
                        else if (src == 6) v = io_val;
                        else begin v = int'(mmem[r[4]]); push_ev(2, r[4], 0); end
                        if (dst == 7) begin mmem[r[4]] = 8'(v); push_ev(1, r[4], v); end
                        else if (dst == 6) push_ev(0, v, 0);
                        else r[dst] = v;
                    end
                    pc = (pc + 1) % 256;
                end
                default: begin
                    if (ins[3]) begin
                        pc = (pc + 1) % 256;
                        push_ev(3, pc, 0);
                    end else begin
                        sv = (r[3] >= 128) ? r[3] - 256 : r[3];
                        cnd = int'(ins[2:0]);
                        case (cnd)
                            0: take = 0;
                            1: take = (sv == 0);
                            2: take = (sv < 0);
                            3: take = (sv <= 0);
                            4: take = 1;
                            5: take = (sv != 0);
                            6: take = (sv >= 0);
                            default: take = (sv > 0);
                        endcase
                        pc = take ? r[0] : (pc + 1) % 256;
                    end
                end
            endcase
        end
    endtask

    // Synchronous instruction ROM: address captured before the edge
    initial begin
        logic [PCW-1:0] ra;
        forever begin
            @(negedge clk);
            ra = imem_addr;
            @(posedge clk);
            #1 imem_data = rom[ra];
        end
    end

    // Data RAM responder
    initial begin
        ev_t t;
        int d;
        logic [7:0] ad;
        forever begin
            @(negedge clk);
            if (dmem_req) begin
                ad = dmem_addr;
                t.kind = dmem_we ? 1 : 2;
                t.a = ad;
                t.b = dmem_we ? dmem_wdata : 8'h00;
                tx_q.push_back(t);
                sb_obs(t.kind, t.a, t.b);
                d = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                repeat (d) @(negedge clk);
                while (ack_hold) @(negedge clk);
                dmem_ack = 1'b1;
                dmem_rdata = dram[ad];
                if (t.kind == 1) dram[ad] = t.b;
                @(negedge clk);
                dmem_ack = 1'b0;
                dmem_rdata = 8'($urandom_range(0, 255));
            end
        end
    end

    // Halt responder
    initial begin
        forever begin
            @(negedge clk);
            if (halted && auto_resume) begin
                sb_obs(3, imem_addr, 8'h00);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                resume = 1'b1;
                @(negedge clk);
                resume = 1'b0;
            end
        end
    end

    // io monitor and request-length tracker
    initial begin
        forever begin
            @(negedge clk);
            if (io_strobe) sb_obs(0, io_out, 8'h00);
            if (dmem_req) req_run++;
            else if (req_run > 0) begin
                req_len_q.push_back(req_run);
                req_run = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic wait_strobe(input int bound, output int cyc);
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (io_strobe) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL strobe_timeout: got no io_strobe expected one within %0d cycles", bound);
        cyc = -1;
    endtask

    task automatic wait_sig(input string name, input bit use_halt, input int bound, output int cyc);
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (use_halt ? halted : dmem_req) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL %s_timeout: got no event expected one within %0d cycles", name, bound);
        cyc = -1;
    endtask

    initial begin
        int c;
        reset = 1'b1; resume = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0; io_in = '0;
        for (int i = 0; i < 256; i++) begin rom[i] = '0; dram[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(imem_addr), 0);
        chk("rst_io_out", 32'(io_out), 0);
        chk("rst_strobe", 32'(io_strobe), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_halted", 32'(halted), 0);

        // IMM then copy to io
        rom[0] = 10'h0A5; rom[1] = 10'h206;
        reset = 1'b0;
        wait_strobe(20, c);
        chk("t1_cycles", 32'(c), 4);
        chk("t1_pc", 32'(imem_addr), 2);
        chk("t1_io_out", 32'(io_out), 32'hA5);
        @(negedge clk);
        chk("t1_strobe_single", 32'(io_strobe), 0);

        // ALU add/sub/shift results dumped to io
        do_reset();
        rom[0] = 10'h0C8; rom[1] = 10'h201; rom[2] = 10'h064; rom[3] = 10'h202;
        rom[4] = 10'h104; rom[5] = 10'h21E; rom[6] = 10'h105; rom[7] = 10'h21E;
        rom[8] = 10'h081; rom[9] = 10'h201; rom[10] = 10'h106; rom[11] = 10'h21E;
        rom[12] = 10'h1FF; rom[13] = 10'h21E;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_strobe(40, c);
            chk($sformatf("t2_alu_%0d", i), 32'(io_out), 32'(t2_exp[i]));
        end

        // Branch conditions on negative r3
        do_reset();
        rom[0] = 10'h080; rom[1] = 10'h203; rom[2] = 10'h010; rom[3] = 10'h306;
        rom[4] = 10'h300; rom[5] = 10'h302; rom[6] = 10'h0EE; rom[7] = 10'h206;
        rom[16] = 10'h206;
        reset = 1'b0;
        wait_strobe(40, c);
        chk("t3_cycles", 32'(c), 14);
        chk("t3_io_out", 32'(io_out), 32'h10);
        chk("t3_pc", 32'(imem_addr), 32'h11);

        // RAM write then read with 3-cycle ack delay
        do_reset();
        dram[32] = 8'h00;
        ack_delay = 3;
        tx_q.delete(); req_len_q.delete();
        rom[0] = 10'h020; rom[1] = 10'h204; rom[2] = 10'h05A; rom[3] = 10'h201;
        rom[4] = 10'h20F; rom[5] = 10'h23A; rom[6] = 10'h216;
        reset = 1'b0;
        wait_strobe(60, c);
        chk("t4_cycles", 32'(c), 22);
        chk("t4_io_out", 32'(io_out), 32'h5A);
        chk("t4_tx_count", 32'(tx_q.size()), 2);
        chk("t4_req_count", 32'(req_len_q.size()), 2);
        if (tx_q.size() == 2 && req_len_q.size() == 2) begin
            chk("t4_wr_kind", 32'(tx_q[0].kind), 1);
            chk("t4_wr_addr", 32'(tx_q[0].a), 32'h20);
            chk("t4_wr_data", 32'(tx_q[0].b), 32'h5A);
            chk("t4_rd_kind", 32'(tx_q[1].kind), 2);
            chk("t4_req_len_wr", 32'(req_len_q[0]), 4);
            chk("t4_req_len_rd", 32'(req_len_q[1]), 4);
        end
        ack_delay = -1;

        // HALT and resume
        do_reset();
        auto_resume = 0;
        for (int i = 0; i < 5; i++) rom[i] = 10'(i + 1);
        rom[5] = 10'h308; rom[6] = 10'h206;
        reset = 1'b0;
        wait_sig("halt", 1'b1, 40, c);
        chk("t5_halt_cycles", 32'(c), 12);
        chk("t5_halt_pc", 32'(imem_addr), 6);
        repeat (10) @(negedge clk);
        chk("t5_still_halted", 32'(halted), 1);
        chk("t5_pc_held", 32'(imem_addr), 6);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        chk("t5_resumed", 32'(halted), 0);
        wait_strobe(10, c);
        chk("t5_resume_cycles", 32'(c), 2);
        chk("t5_io_out", 32'(io_out), 5);
        auto_resume = 1;

        // Reset in the middle of a RAM request, then pc wrap
        do_reset();
        ack_delay = 0; ack_hold = 1;
        rom[0] = 10'h020; rom[1] = 10'h204; rom[2] = 10'h20F;
        reset = 1'b0;
        wait_sig("req", 1'b0, 40, c);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_req_async", 32'(dmem_req), 0);
        chk("t6_pc_async", 32'(imem_addr), 0);
        ack_hold = 0;
        do_reset();
        ack_delay = -1;
        rom[0] = 10'h0FF; rom[1] = 10'h304; rom[255] = 10'h033;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_pc_ff", 32'(imem_addr), 32'hFF);
        repeat (2) @(negedge clk);
        chk("t6_pc_wrap", 32'(imem_addr), 0);

        // Random programs against the reference model
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                rom[i]  = 10'($urandom_range(0, 1023));
                dram[i] = 8'($urandom_range(0, 255));
                mmem[i] = dram[i];
            end
            io_in = 8'($urandom_range(0, 255));
            exp_q.delete();
            model_run(200, int'(io_in));
            sb_on = 1;
            reset = 1'b0;
            c = 0;
            while (exp_q.size() != 0 && c < 5000) begin
                @(negedge clk);
                c++;
            end
            if (exp_q.size() != 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rand_%0d_drain: got %0d events outstanding expected 0", rnd, exp_q.size());
            end
            sb_on = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
